// File: rtl/id_operand_stage.sv
// ID operand stage: IF->ID pipeline register with stall-stable instruction hold,
// N-source operand bypass, load-use hazard detection and MIPS branch/jump resolution.
module id_operand_stage #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int NUM_FWD = 2,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   flush,
  input  logic                   if_valid,
  input  logic [AW-1:0]          if_pc,
  input  logic [31:0]            inst_sram_rdata,
  input  logic [NUM_FWD-1:0]     fwd_we,
  input  logic [5*NUM_FWD-1:0]   fwd_waddr,
  input  logic [DW*NUM_FWD-1:0]  fwd_wdata,
  input  logic                   ex_is_load,
  input  logic [4:0]             ex_waddr,
  output logic [4:0]             rf_raddr1,
  output logic [4:0]             rf_raddr2,
  input  logic [DW-1:0]          rf_rdata1,
  input  logic [DW-1:0]          rf_rdata2,
  output logic                   id_valid,
  output logic [AW-1:0]          id_pc,
  output logic [31:0]            id_inst,
  output logic [DW-1:0]          id_rs_val,
  output logic [DW-1:0]          id_rt_val,
  output logic                   stallreq,
  output logic                   br_e,
  output logic [AW-1:0]          br_addr,
  output logic [CNT_W-1:0]       lu_stall_cnt
);

  logic              valid_r;
  logic [AW-1:0]     pc_r;
  logic              hold_vld_r;
  logic [31:0]       hold_inst_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [31:0]       inst_s;
  logic [4:0]        rs_s;
  logic [4:0]        rt_s;
  logic [DW-1:0]     rs_val_s;
  logic [DW-1:0]     rt_val_s;
  logic              stallreq_s;
  logic              taken_s;
  logic [AW-1:0]     target_s;
  logic [AW-1:0]     pc4_s;
  logic [AW-1:0]     br_off_s;
  logic              rs_neg_s;
  logic              rs_zero_s;
  logic              id_stop_s;
  logic              ex_stop_s;
  logic              unused_s;

  assign id_stop_s = stall[1];
  assign ex_stop_s = stall[2];
  assign unused_s  = ^{stall[0], stall[STALL_W-1:3]};

  // Pipeline register, instruction hold buffer and load-use stall counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_r     <= 1'b0;
      pc_r        <= '0;
      hold_vld_r  <= 1'b0;
      hold_inst_r <= 32'd0;
      cnt_r       <= '0;
    end else begin
      if (flush || (id_stop_s && !ex_stop_s)) begin
        valid_r <= 1'b0;
        pc_r    <= '0;
      end else if (!id_stop_s) begin
        valid_r <= if_valid;
        pc_r    <= if_pc;
      end else begin
        valid_r <= valid_r;
        pc_r    <= pc_r;
      end

      // Any reload, bubble or flush retires the held copy; a full stall captures it once.
      if (flush || !(id_stop_s && ex_stop_s)) begin
        hold_vld_r  <= 1'b0;
        hold_inst_r <= hold_inst_r;
      end else if (valid_r && !hold_vld_r) begin
        hold_vld_r  <= 1'b1;
        hold_inst_r <= inst_sram_rdata;
      end else begin
        hold_vld_r  <= hold_vld_r;
        hold_inst_r <= hold_inst_r;
      end

      if (stallreq_s && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign inst_s = valid_r ? (hold_vld_r ? hold_inst_r : inst_sram_rdata) : 32'd0;
  assign rs_s   = inst_s[25:21];
  assign rt_s   = inst_s[20:16];

  // Operand bypass: walk from oldest to youngest so the lowest index wins.
  always_comb begin
    rs_val_s = rf_rdata1;
    rt_val_s = rf_rdata2;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      rs_val_s = (fwd_we[k] && (fwd_waddr[5*k +: 5] == rs_s)) ? fwd_wdata[DW*k +: DW] : rs_val_s;
      rt_val_s = (fwd_we[k] && (fwd_waddr[5*k +: 5] == rt_s)) ? fwd_wdata[DW*k +: DW] : rt_val_s;
    end
    rs_val_s = (rs_s == 5'd0) ? '0 : rs_val_s;
    rt_val_s = (rt_s == 5'd0) ? '0 : rt_val_s;
  end

  assign stallreq_s = valid_r && ex_is_load && (ex_waddr != 5'd0) &&
                      ((ex_waddr == rs_s) || (ex_waddr == rt_s));

  assign pc4_s     = pc_r + AW'(3'd4);
  assign br_off_s  = {{(AW-18){inst_s[15]}}, inst_s[15:0], 2'b00};
  assign rs_neg_s  = rs_val_s[DW-1];
  assign rs_zero_s = (rs_val_s == '0);

  // Branch/jump decode on the bypassed operands.
  always_comb begin
    taken_s  = 1'b0;
    target_s = pc4_s + br_off_s;
    case (inst_s[31:26])
      6'b000000: begin
        if ((inst_s[5:0] == 6'b001000) || (inst_s[5:0] == 6'b001001)) begin
          taken_s  = 1'b1;
          target_s = AW'(rs_val_s);
        end else begin
          taken_s  = 1'b0;
        end
      end
      6'b000001: begin
        case (rt_s)
          5'b00000, 5'b10000: taken_s = rs_neg_s;
          5'b00001, 5'b10001: taken_s = !rs_neg_s;
          default:            taken_s = 1'b0;
        endcase
      end
      6'b000010, 6'b000011: begin
        taken_s  = 1'b1;
        target_s = {pc4_s[AW-1:28], inst_s[25:0], 2'b00};
      end
      6'b000100: taken_s = (rs_val_s == rt_val_s);
      6'b000101: taken_s = (rs_val_s != rt_val_s);
      6'b000110: taken_s = rs_neg_s || rs_zero_s;
      6'b000111: taken_s = !rs_neg_s && !rs_zero_s;
      default:   taken_s = 1'b0;
    endcase
  end

  assign rf_raddr1    = rs_s;
  assign rf_raddr2    = rt_s;
  assign id_valid     = valid_r;
  assign id_pc        = pc_r;
  assign id_inst      = inst_s;
  assign id_rs_val    = rs_val_s;
  assign id_rt_val    = rt_val_s;
  assign stallreq     = stallreq_s;
  assign br_e         = valid_r && !stallreq_s && taken_s;
  assign br_addr      = br_e ? target_s : '0;
  assign lu_stall_cnt = cnt_r;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed self-checking bench for id_operand_stage.
module tb_id_operand_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] inst_sram_rdata;
  logic [1:0]  fwd_we;
  logic [9:0]  fwd_waddr;
  logic [63:0] fwd_wdata;
  logic        ex_is_load;
  logic [4:0]  ex_waddr;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic        stallreq;
  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] lu_stall_cnt;

  int total = 0;
  int bad   = 0;

  id_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .inst_sram_rdata(inst_sram_rdata),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .ex_is_load(ex_is_load), .ex_waddr(ex_waddr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .stallreq(stallreq), .br_e(br_e), .br_addr(br_addr),
    .lu_stall_cnt(lu_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_inst(input logic [31:0] pc, input logic [31:0] inst);
    stall = 6'b000000;
    flush = 1'b0;
    if_valid = 1'b1;
    if_pc = pc;
    inst_sram_rdata = inst;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    load_inst(32'h0000_1000, 32'h1109_0004);
    tick();
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", id_valid); end
    total++; if (id_inst !== 32'd0) begin bad++; $display("FAIL reset_inst: got %h want 0", id_inst); end
    total++; if (br_e !== 1'b0) begin bad++; $display("FAIL reset_br_e: got %b want 0", br_e); end
    total++; if (lu_stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", lu_stall_cnt); end
    total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL reset_stallreq: got %b want 0", stallreq); end
    rst = 1'b1;
  endtask

  task automatic test_stall_hold();
    load_inst(32'hBFC0_0000, 32'h3408_1234);
    total++; if (id_inst !== 32'h3408_1234) begin bad++; $display("FAIL load_inst: got %h want 34081234", id_inst); end
    stall = 6'b000111;
    if_pc = 32'hBFC0_0004;
    tick();
    inst_sram_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (id_inst !== 32'h3408_1234) begin bad++; $display("FAIL hold_inst[%0d]: got %h want 34081234", i, id_inst); end
      total++; if (id_pc !== 32'hBFC0_0000) begin bad++; $display("FAIL hold_pc[%0d]: got %h want bfc00000", i, id_pc); end
      if (i < 2) tick();
    end
    stall = 6'b000000;
    tick();
    total++; if (id_pc !== 32'hBFC0_0004) begin bad++; $display("FAIL release_pc: got %h want bfc00004", id_pc); end
    total++; if (id_inst !== 32'hDEAD_BEEF) begin bad++; $display("FAIL release_inst: got %h want deadbeef", id_inst); end
    stall = 6'b000010;
    tick();
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL bubble_valid: got %b want 0", id_valid); end
    total++; if (id_pc !== 32'd0) begin bad++; $display("FAIL bubble_pc: got %h want 0", id_pc); end
  endtask

  task automatic test_forwarding();
    load_inst(32'h0000_2000, 32'h0109_1821);
    total++; if (rf_raddr1 !== 5'd8 || rf_raddr2 !== 5'd9) begin bad++; $display("FAIL raddr: got %0d/%0d want 8/9", rf_raddr1, rf_raddr2); end
    rf_rdata1 = 32'h33;
    rf_rdata2 = 32'h44;
    fwd_we = 2'b11;
    fwd_waddr = {5'd8, 5'd8};
    fwd_wdata = {32'h22, 32'h11};
    #1;
    total++; if (id_rs_val !== 32'h11) begin bad++; $display("FAIL fwd_prio: got %h want 11", id_rs_val); end
    total++; if (id_rt_val !== 32'h44) begin bad++; $display("FAIL fwd_rt_rf: got %h want 44", id_rt_val); end
    fwd_we = 2'b10;
    #1;
    total++; if (id_rs_val !== 32'h22) begin bad++; $display("FAIL fwd_src1: got %h want 22", id_rs_val); end
    fwd_we = 2'b00;
    #1;
    total++; if (id_rs_val !== 32'h33) begin bad++; $display("FAIL fwd_none: got %h want 33", id_rs_val); end
    fwd_we = 2'b01;
    fwd_waddr = {5'd8, 5'd9};
    #1;
    total++; if (id_rt_val !== 32'h11) begin bad++; $display("FAIL fwd_rt: got %h want 11", id_rt_val); end
    fwd_we = 2'b11;
    fwd_waddr = {5'd0, 5'd0};
    inst_sram_rdata = 32'h0009_1821;
    #1;
    total++; if (id_rs_val !== 32'd0) begin bad++; $display("FAIL fwd_zero: got %h want 0", id_rs_val); end
    fwd_we = 2'b00;
  endtask

  task automatic test_load_use();
    load_inst(32'h0000_3000, 32'h0109_1821);
    stall = 6'b000111;
    ex_is_load = 1'b1;
    ex_waddr = 5'd9;
    #1;
    total++; if (stallreq !== 1'b1) begin bad++; $display("FAIL lu_req: got %b want 1", stallreq); end
    total++; if (lu_stall_cnt !== 32'd0) begin bad++; $display("FAIL lu_cnt0: got %0d want 0", lu_stall_cnt); end
    tick();
    total++; if (lu_stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_cnt1: got %0d want 1", lu_stall_cnt); end
    tick();
    total++; if (lu_stall_cnt !== 32'd2) begin bad++; $display("FAIL lu_cnt2: got %0d want 2", lu_stall_cnt); end
    ex_waddr = 5'd0;
    #1;
    total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL lu_zero: got %b want 0", stallreq); end
    tick();
    total++; if (lu_stall_cnt !== 32'd2) begin bad++; $display("FAIL lu_cnt_hold: got %0d want 2", lu_stall_cnt); end
    ex_waddr = 5'd8;
    #1;
    total++; if (stallreq !== 1'b1) begin bad++; $display("FAIL lu_rs: got %b want 1", stallreq); end
    ex_is_load = 1'b0;
    ex_waddr = 5'd0;
    stall = 6'b000000;
  endtask

  task automatic test_branch();
    load_inst(32'h0000_1000, 32'h1109_0004);
    rf_rdata1 = 32'd5;
    rf_rdata2 = 32'd5;
    #1;
    total++; if (br_e !== 1'b1) begin bad++; $display("FAIL beq_taken: got %b want 1", br_e); end
    total++; if (br_addr !== 32'h0000_1014) begin bad++; $display("FAIL beq_addr: got %h want 00001014", br_addr); end
    rf_rdata2 = 32'd6;
    #1;
    total++; if (br_e !== 1'b0 || br_addr !== 32'd0) begin bad++; $display("FAIL beq_not: got %b/%h want 0/0", br_e, br_addr); end
    rf_rdata2 = 32'd5;
    ex_is_load = 1'b1;
    ex_waddr = 5'd8;
    #1;
    total++; if (br_e !== 1'b0) begin bad++; $display("FAIL beq_lu: got %b want 0", br_e); end
    ex_is_load = 1'b0;
    ex_waddr = 5'd0;
    inst_sram_rdata = 32'h03E0_0008;
    rf_rdata1 = 32'h8000_0040;
    #1;
    total++; if (br_e !== 1'b1 || br_addr !== 32'h8000_0040) begin bad++; $display("FAIL jr: got %b/%h want 1/80000040", br_e, br_addr); end
    inst_sram_rdata = 32'h0810_0000;
    #1;
    total++; if (br_addr !== 32'h0040_0000) begin bad++; $display("FAIL j_addr: got %h want 00400000", br_addr); end
    inst_sram_rdata = 32'h0500_FFFF;
    rf_rdata1 = 32'h8000_0000;
    #1;
    total++; if (br_e !== 1'b1 || br_addr !== 32'h0000_1000) begin bad++; $display("FAIL bltz: got %b/%h want 1/00001000", br_e, br_addr); end
    rf_rdata1 = 32'd1;
    #1;
    total++; if (br_e !== 1'b0) begin bad++; $display("FAIL bltz_pos: got %b want 0", br_e); end
  endtask

  task automatic test_flush_stall();
    load_inst(32'h0000_4000, 32'h3408_1234);
    stall = 6'b000111;
    tick();
    inst_sram_rdata = 32'hDEAD_BEEF;
    #1;
    total++; if (id_inst !== 32'h3408_1234) begin bad++; $display("FAIL fs_hold: got %h want 34081234", id_inst); end
    flush = 1'b1;
    tick();
    total++; if (id_valid !== 1'b0 || id_inst !== 32'd0) begin bad++; $display("FAIL fs_flush: got %b/%h want 0/0", id_valid, id_inst); end
    flush = 1'b0;
    stall = 6'b000000;
    if_pc = 32'h0000_4004;
    tick();
    total++; if (id_inst !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fs_reload: got %h want deadbeef", id_inst); end
    flush = 1'b1;
    tick();
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL flush_over_load: got %b want 0", id_valid); end
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    load_inst(32'h0000_5000, 32'h0109_1821);
    stall = 6'b000111;
    ex_is_load = 1'b1;
    ex_waddr = 5'd9;
    tick();
    total++; if (lu_stall_cnt !== 32'd3) begin bad++; $display("FAIL b2b_cnt: got %0d want 3", lu_stall_cnt); end
    rst = 1'b0;
    tick();
    total++; if (id_valid !== 1'b0 || lu_stall_cnt !== 32'd0) begin bad++; $display("FAIL rst_mid_stall: got %b/%0d want 0/0", id_valid, lu_stall_cnt); end
    total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL rst_stallreq: got %b want 0", stallreq); end
    rst = 1'b1;
    ex_is_load = 1'b0;
    stall = 6'b000000;
  endtask

  initial begin
    rst = 1'b0;
    stall = 6'b000000;
    flush = 1'b0;
    if_valid = 1'b0;
    if_pc = 32'd0;
    inst_sram_rdata = 32'd0;
    fwd_we = 2'b00;
    fwd_waddr = 10'd0;
    fwd_wdata = 64'd0;
    ex_is_load = 1'b0;
    ex_waddr = 5'd0;
    rf_rdata1 = 32'd0;
    rf_rdata2 = 32'd0;
    test_reset();
    test_stall_hold();
    test_forwarding();
    test_load_use();
    test_branch();
    test_flush_stall();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Parametrised successor of the decode front end. Holds the IF->ID pipeline register and keeps the fetched instruction stable while the stage is stalled.
- Resolves source operands through an N-source forwarding network and detects load-use hazards.
- Resolves all MIPS branches and jumps in ID.
- Sits between the IF stage and instruction SRAM on one side and the decoder/EX stage and regfile on the other. The regfile is external; this block drives its read addresses.

Parameters:
- DW, 32: data width.
- AW, 32: PC width.
- NUM_FWD, 2: number of bypass sources. Index 0 is the youngest (EX) and has the highest priority.
- STALL_W, 6: width of the stall bus.
- CNT_W, 32: width of the load-use stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- stall  in  STALL_W  pipeline stall bus; bit1 = ID input stopped, bit2 = EX input stopped
- flush  in  1  kill the ID contents
- if_valid  in  1  IF presents a valid PC
- if_pc  in  AW  PC of the fetched instruction
- inst_sram_rdata  in  32  SRAM data, valid the cycle after the PC was registered into ID
- fwd_we  in  NUM_FWD  bypass write enables
- fwd_waddr  in  5*NUM_FWD  bypass destination registers; source k occupies bits [5k+4:5k]
- fwd_wdata  in  DW*NUM_FWD  bypass data
- ex_is_load  in  1  the instruction in EX is a load
- ex_waddr  in  5  destination register of the instruction in EX
- rf_raddr1  out  5  regfile read address, = rs
- rf_raddr2  out  5  regfile read address, = rt
- rf_rdata1  in  DW  regfile read data for rf_raddr1
- rf_rdata2  in  DW  regfile read data for rf_raddr2
- id_valid  out  1  ID holds a real instruction
- id_pc  out  AW  PC of the instruction in ID
- id_inst  out  32  instruction in ID; 0 when not valid
- id_rs_val  out  DW  forwarded rs operand
- id_rt_val  out  DW  forwarded rt operand
- stallreq  out  1  load-use stall request
- br_e  out  1  branch or jump taken
- br_addr  out  AW  branch or jump target
- lu_stall_cnt  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset: on a clk edge with rst==0, the following all go to 0:
  - pipeline register (valid, pc)
  - hold_vld and hold_inst
  - lu_stall_cnt
- Consequently id_valid=0, id_inst=0, br_e=0, stallreq=0 from the cycle after the reset edge.
- Pipeline register update, evaluated per edge in this priority order:
  1. flush=1 -> valid=0, pc=0.
  2. stall[1]=1 and stall[2]=0 -> bubble: valid=0, pc=0.
  3. stall[1]=0 -> valid<=if_valid, pc<=if_pc.
  4. Otherwise -> hold the current contents.
- Instruction hold buffer:
  - On the first edge where stall[1]=1 and stall[2]=1, valid=1 and hold_vld=0: hold_inst<=inst_sram_rdata and hold_vld<=1.
  - hold_vld clears on any edge where the pipeline register reloads or bubbles, or on flush.
  - id_inst = hold_vld ? hold_inst : inst_sram_rdata when valid, else 0.
  - Result: id_inst is stable for the whole stall even if the SRAM output changes.
- Operand forwarding (combinational), per operand with address a (rs = id_inst[25:21], rt = id_inst[20:16]):
  - a==0 -> 0.
  - Otherwise the lowest k with fwd_we[k]=1 and fwd_waddr[k]==a -> fwd_wdata[k].
  - Otherwise -> the regfile read data.
- Load-use hazard:
  - stallreq = id_valid & ex_is_load & (ex_waddr!=0) & (ex_waddr==rs | ex_waddr==rt).
  - The check is conservative: both fields count as sources for every instruction.
  - lu_stall_cnt increments on each edge with stallreq=1 and saturates at all-ones.
- Branch resolution (combinational on the forwarded operands), with pc4 = id_pc + 4:
  - beq: taken if rs==rt.
  - bne: taken if rs!=rt.
  - bgez / bltz (REGIMM): compare rs to 0 as signed.
  - bgtz / blez: compare rs to 0 as signed.
  - Conditional branch target = pc4 + sign_ext(imm)<<2.
  - j / jal: target = {pc4[AW-1:28], instr_index, 2'b00}.
  - jr / jalr: target = rs.
  - br_e = id_valid & ~stallreq & taken.
  - br_addr = target when br_e=1, else 0.
- Simultaneous events:
  - flush together with stall: flush wins.
  - flush together with stallreq: stallreq drops the next cycle because valid=0.
  - rst==0 overrides everything, including in the middle of a stall.

Test Plan:
- Reset: hold rst=0 for 2 cycles while presenting a valid instruction -> id_valid=0, id_inst=0, br_e=0, lu_stall_cnt=0.
- Stall hold: load pc 0xBFC00000 with inst 0x3408_1234 (ori). Assert stall=6'b000111 for 3 cycles while inst_sram_rdata changes to 0xDEADBEEF -> id_inst stays 0x34081234 and id_pc stays 0xBFC00000 throughout. Release the stall -> the next instruction loads.
- Forwarding priority: rs=$8, fwd_we=2'b11, fwd_waddr[0]=8 with data 0x11, fwd_waddr[1]=8 with data 0x22, rf_rdata1=0x33 -> id_rs_val=0x11. Drop fwd_we[0] -> 0x22. Set rs=$0 -> 0.
- Load-use: ID holds addu $3,$8,$9 with ex_is_load=1 and ex_waddr=9 -> stallreq=1 and lu_stall_cnt increments by 1 per cycle. ex_waddr=0 -> stallreq=0.
- Branches: beq at id_pc 0x1000 with imm 0x0004 and equal operands -> br_e=1, br_addr=0x1014. With unequal operands -> br_e=0, br_addr=0. jr $31 with $31=0x8000_0040 -> br_addr=0x80000040. Taken beq while stallreq=1 -> br_e=0.
- Flush during stall: assert flush and stall together -> id_valid=0 and hold_vld cleared on the next edge.
